spi_byte_engine: RTL and testbench

Hardware SPI byte shifter that sits downstream of the ctrl-code decoder on the extension board, replacing software bit-banging of MOSI/SCK. The ctrl decoder hands it a byte strobe and a slave-select value. The block shifts the byte out in SPI mode 0 while capturing the returned byte from the selected MISO line, then presents the result for the GBUS read mux. All state is held in the block, which runs on a single clock.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clkdiv.sv | 39 +++
 rtl/spi_byte_engine.sv | 196 +++++++++++++++++++
 tb/tb_spi_byte_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte engine and its clock divider.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FIN
  } spi_state_e;

  localparam int unsigned HALF_DIV_MIN = 1;
  localparam int unsigned HALF_DIV_MAX = 15;
  localparam int unsigned DIV_W        = $clog2(HALF_DIV_MAX + 1);

  localparam logic [1:0] NSS_IDLE = 2'b11;

endpackage

// File: rtl/spi_clkdiv.sv
// SCK half-period divider: tick is high in the last cycle of each HALF_DIV-long phase.
// restart zeroes the count so every FSM state lasts exactly HALF_DIV cycles from entry.
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  // Out-of-range settings are pulled back into the legal window.
  localparam int unsigned HALF_DIV_EFF =
    (HALF_DIV < HALF_DIV_MIN) ? HALF_DIV_MIN :
    (HALF_DIV > HALF_DIV_MAX) ? HALF_DIV_MAX : HALF_DIV;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(HALF_DIV_EFF - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: WDATA goes out on MOSI while the selected MISO is captured into RDATA.
// Define SPI_BURST_EN for a one-byte holding register that streams back-to-back bytes without an IDLE gap.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR,
  input  logic [7:0] WDATA,
  input  logic       SS_WR,
  input  logic [1:0] SS_DATA,
  input  logic [2:0] MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic [1:0] nSS,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  spi_state_e state_q, state_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rdata_q, rdata_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bit_cnt_inc;
  logic       sck_q, sck_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic [1:0] nss_q, nss_d;
  logic [1:0] ss_pend_q, ss_pend_d;
  logic       ss_pend_vld_q, ss_pend_vld_d;
  logic       busy, misox, tick, restart;
`ifdef SPI_BURST_EN
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
`endif

  assign busy  = (state_q != IDLE);
  assign misox = (MISO[0] & ~nss_q[0]) | (MISO[1] & ~nss_q[1]) | (MISO[2] & nss_q[0] & nss_q[1]);
  // Bit 3 is the terminal flag: set when the eighth bit has just finished.
  assign bit_cnt_inc = {1'b0, bit_cnt_q} + 4'd1;
  assign restart     = (state_d != state_q);

  spi_clkdiv #(.HALF_DIV(HALF_DIV)) u_clkdiv (
    .clk     (CLK),
    .rst     (RST),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d       = state_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    rdata_d       = rdata_q;
    bit_cnt_d     = bit_cnt_q;
    sck_d         = sck_q;
    done_d        = 1'b0;
    ovr_d         = ovr_q;
    nss_d         = nss_q;
    ss_pend_d     = ss_pend_q;
    ss_pend_vld_d = ss_pend_vld_q;
`ifdef SPI_BURST_EN
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
`endif

    if (SS_WR) begin
      if (busy) begin
        ss_pend_d     = SS_DATA;
        ss_pend_vld_d = 1'b1;
      end else begin
        nss_d = SS_DATA;
      end
    end

    if (WR && busy) begin
`ifdef SPI_BURST_EN
      if (hold_vld_q) begin
        ovr_d = 1'b1;
      end else begin
        hold_d     = WDATA;
        hold_vld_d = 1'b1;
      end
`else
      ovr_d = 1'b1;
`endif
    end

    case (state_q)
      IDLE: begin
        if (WR) begin
          state_d   = LOW;
          tx_sr_d   = WDATA;
          bit_cnt_d = '0;
          ovr_d     = 1'b0;
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[6:0], misox};
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_inc[2:0];
          if (bit_cnt_inc[3]) begin
            state_d = FIN;
            rdata_d = rx_sr_q;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      FIN: begin
        state_d = IDLE;
`ifdef SPI_BURST_EN
        if (hold_vld_q) begin
          state_d    = LOW;
          tx_sr_d    = hold_q;
          hold_vld_d = 1'b0;
        end else if (WR) begin
          state_d    = LOW;
          tx_sr_d    = WDATA;
          hold_vld_d = 1'b0;
        end
`endif
        // A deferred select only lands when the bus is about to go quiet.
        if (state_d == IDLE && ss_pend_vld_d) begin
          nss_d         = ss_pend_d;
          ss_pend_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rdata_q       <= '0;
      bit_cnt_q     <= '0;
      sck_q         <= 1'b0;
      done_q        <= 1'b0;
      ovr_q         <= 1'b0;
      nss_q         <= NSS_IDLE;
      ss_pend_q     <= NSS_IDLE;
      ss_pend_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      rdata_q       <= rdata_d;
      bit_cnt_q     <= bit_cnt_d;
      sck_q         <= sck_d;
      done_q        <= done_d;
      ovr_q         <= ovr_d;
      nss_q         <= nss_d;
      ss_pend_q     <= ss_pend_d;
      ss_pend_vld_q <= ss_pend_vld_d;
    end
  end

`ifdef SPI_BURST_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  // MOSI is the shift register MSB, so it only moves at load or on an SCK fall.
  assign MOSI  = tx_sr_q[7];
  assign SCK   = sck_q;
  assign nSS   = nss_q;
  assign RDATA = rdata_q;
  assign BUSY  = busy;
  assign DONE  = done_q;
  assign OVR   = ovr_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Randomized bench for spi_byte_engine against a cycle-count/transaction model of the SPI byte engine.
module tb_spi_byte_engine;

  localparam int H  = 2;
  localparam int NB = 16 * H;

  logic       CLK = 1'b0;
  logic       RST, WR, SS_WR, MOSI, SCK, BUSY, DONE, OVR;
  logic [7:0] WDATA, RDATA;
  logic [1:0] SS_DATA, nSS;
  logic [2:0] MISO;

  int n_run  = 0;
  int n_fail = 0;

  logic [1:0] nss_m;
  logic       ovr_m;

  spi_byte_engine #(.HALF_DIV(H)) dut (
    .CLK(CLK), .RST(RST), .WR(WR), .WDATA(WDATA), .SS_WR(SS_WR), .SS_DATA(SS_DATA),
    .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .nSS(nSS), .RDATA(RDATA), .BUSY(BUSY),
    .DONE(DONE), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Slave side: the addressed slave drives bit b, unaddressed lines carry noise.
  function automatic logic [2:0] slave_miso(input logic [1:0] ss, input logic b, input logic [2:0] noise);
    logic [2:0] m;
    m = noise;
    case (ss)
      2'b10:   m[0] = b;
      2'b01:   m[1] = b;
      2'b11:   m[2] = b;
      default: begin m[0] = b; m[1] = 1'b0; end
    endcase
    return m;
  endfunction

  task automatic set_ss(input logic [1:0] v);
    SS_WR = 1'b1; SS_DATA = v;
    @(negedge CLK);
    SS_WR = 1'b0;
    check_eq("ss_idle", nSS, v);
    nss_m = v;
  endtask

  task automatic idle_chk(input int n, input string tag);
    int busy_seen = 0;
    int done_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      MISO = 3'($urandom);
      if (BUSY !== 1'b0) busy_seen++;
      if (DONE !== 1'b0) done_seen++;
    end
    check_eq({tag, "_busy"}, busy_seen, 0);
    check_eq({tag, "_done"}, done_seen, 0);
  endtask

  // One byte: ss_j=0 writes select with WR, ss_j>0 writes it mid-byte, poke_j>0 issues an extra WR.
  task automatic run_xfer(input logic [7:0] wd, input logic [7:0] rp, input bit loop,
                          input int ss_j, input logic [1:0] ss_v, input int poke_j);
    int sck_err = 0, mosi_err = 0, busy_err = 0, nss_err = 0;
    int done_cnt = 0, done_at = 0, rises = 0, exp_sck;
    logic sck_prev = 1'b0;
    logic [1:0] nss_now, nss_after, nss_exp;
    logic [7:0] exp_rd;
    logic b;
    nss_now = nss_m; nss_after = nss_m;
    exp_rd = loop ? wd : rp;
    WR = 1'b1; WDATA = wd;
    if (ss_j == 0) begin
      SS_WR = 1'b1; SS_DATA = ss_v; nss_now = ss_v; nss_after = ss_v;
    end
    MISO = slave_miso(nss_now, rp[7], 3'($urandom));
    ovr_m = 1'b0;
    for (int j = 1; j <= NB + 3; j++) begin
      @(negedge CLK);
      WR = 1'b0; SS_WR = 1'b0;
      if (j == 1) check_eq("ovr_cleared", OVR, 0);
      exp_sck = (j <= NB) ? ((j - 1) / H) % 2 : 0;
      if (SCK !== exp_sck[0]) sck_err++;
      if (BUSY !== (j <= NB + 1)) busy_err++;
      if (j <= NB && MOSI !== wd[7 - (j - 1) / (2 * H)]) mosi_err++;
      if (DONE === 1'b1) begin done_cnt++; done_at = j; end
      if (j == NB + 1) check_eq("rdata", RDATA, exp_rd);
      nss_exp = (j <= NB) ? nss_now : nss_after;
      if (j != NB + 1 && nSS !== nss_exp) nss_err++;
      if (SCK && !sck_prev) rises++;
      sck_prev = SCK;
      b = loop ? MOSI : ((rises < 8) ? rp[7 - rises] : 1'b0);
      MISO = slave_miso(nss_now, b, 3'($urandom));
      if (j == ss_j) begin SS_WR = 1'b1; SS_DATA = ss_v; nss_after = ss_v; end
      if (j == poke_j) begin WR = 1'b1; WDATA = 8'h22; ovr_m = 1'b1; end
    end
    check_eq("done_cnt", done_cnt, 1);
    check_eq("done_at", done_at, NB + 1);
    check_eq("sck_wave", sck_err, 0);
    check_eq("mosi_bits", mosi_err, 0);
    check_eq("busy_wave", busy_err, 0);
    check_eq("nss_wave", nss_err, 0);
    check_eq("ovr_end", OVR, ovr_m);
    check_eq("rdata_hold", RDATA, exp_rd);
    nss_m = nss_after;
  endtask

`ifdef SPI_BURST_EN
  task automatic burst(input bit third);
    int rises = 0, dones = 0, gaps = 0;
    logic sp = 1'b0;
    WR = 1'b1; WDATA = 8'h81;
    for (int j = 1; j <= 2 * NB + 12; j++) begin
      @(negedge CLK);
      WR = 1'b0;
      if (SCK && !sp) rises++;
      sp = SCK;
      if (DONE === 1'b1) dones++;
      if (j <= 2 * NB + 2 && BUSY !== 1'b1) gaps++;
      if (j > 2 * NB + 2 && BUSY !== 1'b0) gaps++;
      if (j == 10) begin WR = 1'b1; WDATA = 8'h7E; end
      if (third && j == 20) begin WR = 1'b1; WDATA = 8'h55; end
      MISO = 3'($urandom);
    end
    check_eq("burst_rises", rises, 16);
    check_eq("burst_dones", dones, 2);
    check_eq("burst_busy", gaps, 0);
    check_eq("burst_ovr", OVR, third);
    ovr_m = third;
  endtask
`endif

  initial begin
    int edges, mode, sj;
    logic sp;
    logic [1:0] v;
    RST = 1'b1; WR = 1'b0; WDATA = '0; SS_WR = 1'b0; SS_DATA = 2'b11; MISO = '0;
    nss_m = 2'b11; ovr_m = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_mosi", MOSI, 0);
    check_eq("rst_sck", SCK, 0);
    check_eq("rst_nss", nSS, 2'b11);
    check_eq("rst_rdata", RDATA, 8'h00);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_ovr", OVR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Reset in the middle of a byte.
    set_ss(2'b10);
    WR = 1'b1; WDATA = 8'hA5;
    @(negedge CLK);
    WR = 1'b0;
    edges = 0; sp = SCK;
    for (int j = 2; j <= 40 && edges < 5; j++) begin
      @(negedge CLK);
      if (SCK !== sp) edges++;
      sp = SCK;
    end
    check_eq("mid_edges", edges, 5);
    RST = 1'b1;
    #1;
    check_eq("mid_mosi", MOSI, 0);
    check_eq("mid_sck", SCK, 0);
    check_eq("mid_nss", nSS, 2'b11);
    check_eq("mid_busy", BUSY, 0);
    check_eq("mid_done", DONE, 0);
    check_eq("mid_ovr", OVR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    nss_m = 2'b11; ovr_m = 1'b0;
    idle_chk(40, "post_rst");
    check_eq("post_rst_rdata", RDATA, 8'h00);

    // Loopback on slave 0.
    set_ss(2'b10);
    run_xfer(8'h3C, 8'h00, 1'b1, -1, 2'b00, -1);

    // Nobody selected: the spare MISO line feeds the capture.
    set_ss(2'b11);
    run_xfer(8'h00, 8'hFF, 1'b0, -1, 2'b00, -1);

`ifndef SPI_BURST_EN
    run_xfer(8'h11, 8'h96, 1'b0, -1, 2'b00, 10);
    idle_chk(40, "after_ovr");
`else
    burst(1'b0);
    burst(1'b1);
`endif

    // Select written mid-byte takes effect only once the byte is over.
    set_ss(2'b10);
    run_xfer(8'h5A, 8'hC3, 1'b0, 5, 2'b01, -1);

    // Select and byte in the same cycle.
    run_xfer(8'hE7, 8'h18, 1'b0, 0, 2'b11, -1);

    for (int k = 0; k < 8; k++) begin
      mode = int'($urandom_range(0, 2));
      v    = 2'($urandom);
      sj   = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(2, NB)) : -1;
      run_xfer(8'($urandom), 8'($urandom), 1'b0, sj, v, -1);
    end
    idle_chk(10, "tail");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
